// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   - Baud divider constants for a 50 MHz system clock.
//   - Data width and baud counter width.
//   - Transmit FSM state encoding.
//   - Parity helper.
package uart_pkg;

  localparam int unsigned CLK_DIV_9600   = 5208;
  localparam int unsigned CLK_DIV_115200 = 434;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BAUD_CNT_W = 13;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Even parity is the plain XOR of the data bits; odd parity inverts it.
  function automatic logic calc_parity(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/bps_tx.sv
// Baud tick generator for the transmitter.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   en       - count enable; the counter is held at 0 while low
//   bit_tick - high during the last cycle of each bit period
module bps_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_9600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_tick
);

  localparam logic [BAUD_CNT_W-1:0] LAST = BAUD_CNT_W'(CLK_DIV - 1);

  logic [BAUD_CNT_W-1:0] cnt_q;
  logic [BAUD_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Bit timing from the internal bps_tx tick generator.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   tx_start - send request, level-sampled; accepted only when not busy
//   tx_data  - byte to send, latched on an accepted request
//   tx_busy  - high while a frame is in progress
//   tx_done  - one-cycle pulse when the last stop bit completes
//   txd      - serial line, idle high
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_9600,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              txd
);

  localparam logic [2:0] LAST_IDX  = 3'(DATA_W - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic       PAR_EN    = (PARITY_EN != 0);
  localparam logic       PAR_ODD   = (PARITY_ODD != 0);

  tx_state_e         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [2:0]        bit_idx_q;
  logic              stop_cnt_q;
  logic              parity_q;
  logic              txd_q;
  logic              busy_q;
  logic              done_q;

  logic              parity_d;
  logic              bit_tick;

  assign parity_d = calc_parity(tx_data, PAR_ODD);

  // Counting is enabled by the registered busy flag, so the counter is
  // at 0 on the first cycle of the start bit and each bit lasts CLK_DIV.
  bps_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_bps (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (busy_q),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_start) begin
            state_q    <= START;
            shift_q    <= tx_data;
            parity_q   <= parity_d;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        START: begin
          if (bit_tick) begin
            state_q <= DATA;
            txd_q   <= shift_q[0];
            shift_q <= {1'b0, shift_q[DATA_W-1:1]};
          end
        end
        DATA: begin
          // bit_idx_q names the data bit currently on the line.
          if (bit_tick) begin
            if (bit_idx_q == LAST_IDX) begin
              bit_idx_q <= '0;
              if (PAR_EN) begin
                state_q <= PARITY;
                txd_q   <= parity_q;
              end else begin
                state_q <= STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              txd_q     <= shift_q[0];
              shift_q   <= {1'b0, shift_q[DATA_W-1:1]};
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            state_q <= STOP;
            txd_q   <= 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (stop_cnt_q == LAST_STOP) begin
              state_q    <= IDLE;
              stop_cnt_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign txd     = txd_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx. Two instances with CLK_DIV=16:
//   dut_a: no parity, 1 stop bit  (10-bit frames)
//   dut_b: even parity, 2 stop bits (12-bit frames)
// Stimulus pushes hand-computed frames (bit 0 = first bit on the line)
// into a per-instance queue; a monitor per instance captures every frame
// from txd and compares.
module tb_uart_tx;

  localparam int unsigned DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic [7:0] data_a, data_b;
  logic       busy_a, busy_b, done_a, done_b, txd_a, txd_b;

  int compared   = 0;
  int mismatched = 0;

  logic [11:0] exp_a[$];
  logic [11:0] exp_b[$];

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_DIV   (DIV),
    .PARITY_EN (0),
    .PARITY_ODD(0),
    .STOP_BITS (1)
  ) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(start_a),
    .tx_data (data_a),
    .tx_busy (busy_a),
    .tx_done (done_a),
    .txd     (txd_a)
  );

  uart_tx #(
    .CLK_DIV   (DIV),
    .PARITY_EN (1),
    .PARITY_ODD(0),
    .STOP_BITS (2)
  ) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(start_b),
    .tx_data (data_b),
    .tx_busy (busy_b),
    .tx_done (done_b),
    .txd     (txd_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic txd_of(input int d);
    return (d == 0) ? txd_a : txd_b;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic done_of(input int d);
    return (d == 0) ? done_a : done_b;
  endfunction

  task automatic monitor(input int d);
    int unsigned nb;
    logic        prev;
    logic [11:0] got;
    logic [11:0] want;
    logic        lvl;
    logic        hold_ok;
    logic        aborted;
    logic        have;
    nb   = (d == 0) ? 10 : 12;
    prev = 1'b0;
    lvl  = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && busy_of(d) && !prev) begin
        got     = '0;
        hold_ok = 1'b1;
        aborted = 1'b0;
        for (int unsigned k = 0; k < nb * DIV && !aborted; k++) begin
          if (k != 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
          end else begin
            if (k % DIV == 0) begin
              lvl          = txd_of(d);
              got[k / DIV] = lvl;
            end
            if (txd_of(d) !== lvl || busy_of(d) !== 1'b1 || done_of(d) !== 1'b0)
              hold_ok = 1'b0;
          end
        end
        if (!aborted) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
          end else begin
            chk($sformatf("end_busy_%0d", d), 32'(busy_of(d)), 32'd0);
            chk($sformatf("end_done_%0d", d), 32'(done_of(d)), 32'd1);
            chk($sformatf("end_txd_%0d", d), 32'(txd_of(d)), 32'd1);
          end
        end
        want = '0;
        have = 1'b0;
        if (d == 0) begin
          if (exp_a.size() > 0) begin have = 1'b1; want = exp_a.pop_front(); end
        end else begin
          if (exp_b.size() > 0) begin have = 1'b1; want = exp_b.pop_front(); end
        end
        if (!have) begin
          chk($sformatf("unexpected_frame_%0d", d), 32'd1, 32'd0);
        end else if (!aborted) begin
          chk($sformatf("frame_bits_%0d", d), 32'(got), 32'(want));
          chk($sformatf("bit_hold_%0d", d), 32'(hold_ok), 32'd1);
        end
        prev = 1'b0;
      end else begin
        if (rst_n && done_of(d)) chk($sformatf("spurious_done_%0d", d), 32'd1, 32'd0);
        prev = busy_of(d);
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic send(input int d, input logic [7:0] v);
    @(negedge clk);
    if (d == 0) begin start_a = 1'b1; data_a = v; end
    else        begin start_b = 1'b1; data_b = v; end
    @(negedge clk);
    if (d == 0) start_a = 1'b0;
    else        start_b = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int unsigned n;
    n = 0;
    while (busy_of(d) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk($sformatf("timeout_idle_%0d", d), 32'd1, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int unsigned idle_bad;
    int unsigned n;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    data_a  = '0;
    data_b  = '0;
    repeat (3) @(negedge clk);
    chk("reset_txd", 32'(txd_a), 32'd1);
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_done", 32'(done_a), 32'd0);
    rst_n = 1'b1;

    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || busy_a !== 1'b0 || txd_b !== 1'b1 || busy_b !== 1'b0)
        idle_bad++;
    end
    chk("idle_levels", 32'(idle_bad), 32'd0);

    // 0x55, 8N1
    exp_a.push_back({2'b00, 1'b1, 8'h55, 1'b0});
    send(0, 8'h55);
    wait_idle(0);

    // 0x07, even parity (=1), 2 stop bits
    exp_b.push_back({2'b11, 1'b1, 8'h07, 1'b0});
    send(1, 8'h07);
    wait_idle(1);

    // 0xA3 with a 0xFF request at cycle 50 that must be ignored
    exp_a.push_back({2'b00, 1'b1, 8'hA3, 1'b0});
    send(0, 8'hA3);
    repeat (49) @(negedge clk);
    start_a = 1'b1;
    data_a  = 8'hFF;
    @(negedge clk);
    start_a = 1'b0;
    wait_idle(0);
    repeat (40) @(negedge clk);

    // Back-to-back: tx_start held, data changes after acceptance
    exp_a.push_back({2'b00, 1'b1, 8'h00, 1'b0});
    exp_a.push_back({2'b00, 1'b1, 8'hFF, 1'b0});
    @(negedge clk);
    start_a = 1'b1;
    data_a  = 8'h00;
    @(negedge clk);
    data_a = 8'hFF;
    n = 0;
    while (!done_a && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("timeout_b2b_done", 32'd1, 32'd0);
    @(negedge clk);
    chk("b2b_next_busy", 32'(busy_a), 32'd1);
    chk("b2b_next_start_bit", 32'(txd_a), 32'd0);
    start_a = 1'b0;
    wait_idle(0);

    // Reset during data bit 3 of 0x00, then a clean frame
    exp_a.push_back({2'b00, 1'b1, 8'h00, 1'b0});
    send(0, 8'h00);
    repeat (70) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_txd", 32'(txd_a), 32'd1);
    chk("rst_mid_busy", 32'(busy_a), 32'd0);
    chk("rst_mid_done", 32'(done_a), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp_a.push_back({2'b00, 1'b1, 8'h3C, 1'b0});
    send(0, 8'h3C);
    wait_idle(0);

    repeat (20) @(negedge clk);
    chk("queue_a_empty", 32'(exp_a.size()), 32'd0);
    chk("queue_b_empty", 32'(exp_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
